// File: rtl/badminton_hit_detector_b_pkg.sv
// Shared types for the player-B hit detector: collision boxes, racket state names,
// detector FSM states and the per-swing outgoing velocity tables.
package collision_package;

  typedef struct packed {
    logic [11:0] size_x;
    logic [11:0] size_y;
    logic [11:0] pos_x;
    logic [11:0] pos_y;
  } collision_box;

endpackage

package hit_package;

  typedef enum logic [4:0] {
    Idle_1, Idle_2,
    Up_1, Up_2, Up_3, Up_4, Up_5, Up_6, Up_7,
    Down_1, Down_2, Down_3, Down_4, Down_5, Down_6,
    Down_7, Down_8, Down_9, Down_10, Down_11, Down_12
  } pat_B_state_name;

  localparam int unsigned NUM_STATES = 21;

  typedef enum logic [1:0] {S_WAIT, S_EVAL, S_REPORT, S_COOLDOWN} hit_fsm_e;

  // {vx, vy} in px/frame, positive vy points down the screen
  localparam logic signed [11:0] hit_velocity [NUM_STATES][2] = '{
    '{ 12'sd0,   12'sd0  },
    '{ 12'sd0,   12'sd0  },
    '{-12'sd3,  -12'sd7  },
    '{-12'sd4,  -12'sd8  },
    '{-12'sd5,  -12'sd9  },
    '{-12'sd6,  -12'sd10 },
    '{-12'sd7,  -12'sd11 },
    '{-12'sd8,  -12'sd12 },
    '{-12'sd9,  -12'sd13 },
    '{-12'sd3,   12'sd0  },
    '{-12'sd4,   12'sd0  },
    '{-12'sd5,   12'sd1  },
    '{-12'sd6,   12'sd1  },
    '{-12'sd7,   12'sd1  },
    '{-12'sd8,   12'sd2  },
    '{-12'sd9,   12'sd2  },
    '{-12'sd10,  12'sd2  },
    '{-12'sd11,  12'sd3  },
    '{-12'sd12,  12'sd3  },
    '{-12'sd13,  12'sd3  },
    '{-12'sd14,  12'sd4  }
  };

  localparam logic hittable [NUM_STATES] = '{
    1'b0, 1'b0,
    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1
  };

  localparam logic hit_kind_of [NUM_STATES] = '{
    1'b0, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1
  };

endpackage

// File: rtl/badminton_hit_detector_b_collision_overlap.sv
// Combinational axis-aligned overlap test between two collision boxes.
// Touching edges and zero-size boxes never overlap.
module collision_overlap
  import collision_package::*;
(
  input  collision_box a_i,
  input  collision_box b_i,
  output logic         overlap_o
);

  logic [12:0] a_x_end, a_y_end, b_x_end, b_y_end;
  logic        sizes_nonzero;

  always_comb begin
    // Box ends carry a 13th bit so boxes near the 4095 edge do not wrap
    a_x_end = {1'b0, a_i.pos_x} + {1'b0, a_i.size_x};
    a_y_end = {1'b0, a_i.pos_y} + {1'b0, a_i.size_y};
    b_x_end = {1'b0, b_i.pos_x} + {1'b0, b_i.size_x};
    b_y_end = {1'b0, b_i.pos_y} + {1'b0, b_i.size_y};

    sizes_nonzero = (a_i.size_x != '0) && (a_i.size_y != '0) &&
                    (b_i.size_x != '0) && (b_i.size_y != '0);

    overlap_o = sizes_nonzero &&
                ({1'b0, a_i.pos_x} < b_x_end) && ({1'b0, b_i.pos_x} < a_x_end) &&
                ({1'b0, a_i.pos_y} < b_y_end) && ({1'b0, b_i.pos_y} < a_y_end);
  end

endmodule

// File: rtl/badminton_hit_detector_b.sv
// Player-B hit detector: snapshots racket/shuttle per frame, reports hits over
// valid/ready to the shuttle physics block, then locks out re-hits for a few frames.
module badminton_hit_detector_b
  import collision_package::*;
  import hit_package::*;
#(
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned COUNT_W         = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                write_finished,
  input  collision_box        pat_B_collision,
  input  pat_B_state_name     pat_B_curr_state_name,
  input  collision_box        shuttle_box,
  input  logic                shuttle_in_flight,
  output logic                hit_valid,
  input  logic                hit_ready,
  output logic signed [11:0]  hit_vx,
  output logic signed [11:0]  hit_vy,
  output logic                hit_kind,
  output logic [COUNT_W-1:0]  hit_count
);

  localparam int unsigned CD_W = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [CD_W-1:0] CD_INIT = CD_W'(COOLDOWN_FRAMES);

  hit_fsm_e           state_q, state_d;
  collision_box       snap_pat_q, snap_pat_d;
  collision_box       snap_shuttle_q, snap_shuttle_d;
  pat_B_state_name    snap_state_q, snap_state_d;
  logic               snap_flight_q, snap_flight_d;
  logic               valid_q, valid_d;
  logic signed [11:0] vx_q, vx_d, vy_q, vy_d;
  logic               kind_q, kind_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [CD_W-1:0]    cd_q, cd_d;
  logic               overlap;
  logic               racket_active;

  collision_overlap u_overlap (
    .a_i       (snap_pat_q),
    .b_i       (snap_shuttle_q),
    .overlap_o (overlap)
  );

  assign racket_active = (snap_pat_q.pos_x != '0) || (snap_pat_q.pos_y != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_WAIT;
      snap_pat_q     <= '0;
      snap_shuttle_q <= '0;
      snap_state_q   <= Idle_1;
      snap_flight_q  <= 1'b0;
      valid_q        <= 1'b0;
      vx_q           <= '0;
      vy_q           <= '0;
      kind_q         <= 1'b0;
      count_q        <= '0;
      cd_q           <= '0;
    end else begin
      state_q        <= state_d;
      snap_pat_q     <= snap_pat_d;
      snap_shuttle_q <= snap_shuttle_d;
      snap_state_q   <= snap_state_d;
      snap_flight_q  <= snap_flight_d;
      valid_q        <= valid_d;
      vx_q           <= vx_d;
      vy_q           <= vy_d;
      kind_q         <= kind_d;
      count_q        <= count_d;
      cd_q           <= cd_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    snap_pat_d     = snap_pat_q;
    snap_shuttle_d = snap_shuttle_q;
    snap_state_d   = snap_state_q;
    snap_flight_d  = snap_flight_q;
    valid_d        = valid_q;
    vx_d           = vx_q;
    vy_d           = vy_q;
    kind_d         = kind_q;
    count_d        = count_q;
    cd_d           = cd_q;

    case (state_q)
      S_WAIT: begin
        if (write_finished) begin
          snap_pat_d     = pat_B_collision;
          snap_shuttle_d = shuttle_box;
          snap_state_d   = pat_B_curr_state_name;
          snap_flight_d  = shuttle_in_flight;
          state_d        = S_EVAL;
        end
      end
      S_EVAL: begin
        if (snap_flight_q && racket_active && hittable[snap_state_q] && overlap) begin
          vx_d    = hit_velocity[snap_state_q][0];
          vy_d    = hit_velocity[snap_state_q][1];
          kind_d  = hit_kind_of[snap_state_q];
          valid_d = 1'b1;
          state_d = S_REPORT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_REPORT: begin
        // Frame ticks here are dropped, even one landing on the accepting edge
        if (hit_ready) begin
          valid_d = 1'b0;
          count_d = (count_q == '1) ? count_q : count_q + 1'b1;
          cd_d    = CD_INIT;
          state_d = (COOLDOWN_FRAMES == 0) ? S_WAIT : S_COOLDOWN;
        end
      end
      S_COOLDOWN: begin
        if (write_finished) begin
          cd_d = cd_q - 1'b1;
          if (cd_q == CD_W'(1)) state_d = S_WAIT;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  assign hit_valid = valid_q;
  assign hit_vx    = vx_q;
  assign hit_vy    = vy_q;
  assign hit_kind  = kind_q;
  assign hit_count = count_q;

endmodule

// File: tb/tb_badminton_hit_detector_b.sv
// Self-checking bench for the player-B hit detector (cooldown 4 and cooldown 0 instances).
module tb_badminton_hit_detector_b;
  import collision_package::*;
  import hit_package::*;

  logic clk = 1'b0;
  logic rst_n, write_finished, shuttle_in_flight, hit_ready;
  collision_box pat_B_collision, shuttle_box;
  pat_B_state_name pat_B_curr_state_name;

  logic hit_valid, hit_kind, z_valid, z_kind;
  logic signed [11:0] hit_vx, hit_vy, z_vx, z_vy;
  logic [7:0] hit_count, z_count;

  int vectors = 0;
  int miscompares = 0;
  int exp_count = 0;
  int c_ax, c_ay, c_aw, c_ah, c_bx, c_by, c_bw, c_bh, c_s;
  bit c_fl;

  always #5 clk = ~clk;

  badminton_hit_detector_b #(.COOLDOWN_FRAMES(4), .COUNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .write_finished(write_finished),
    .pat_B_collision(pat_B_collision), .pat_B_curr_state_name(pat_B_curr_state_name),
    .shuttle_box(shuttle_box), .shuttle_in_flight(shuttle_in_flight),
    .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_vx(hit_vx), .hit_vy(hit_vy),
    .hit_kind(hit_kind), .hit_count(hit_count)
  );

  badminton_hit_detector_b #(.COOLDOWN_FRAMES(0), .COUNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .write_finished(write_finished),
    .pat_B_collision(pat_B_collision), .pat_B_curr_state_name(pat_B_curr_state_name),
    .shuttle_box(shuttle_box), .shuttle_in_flight(shuttle_in_flight),
    .hit_valid(z_valid), .hit_ready(hit_ready), .hit_vx(z_vx), .hit_vy(z_vy),
    .hit_kind(z_kind), .hit_count(z_count)
  );

  // Reference swing table from the design rules: Up_k -> (-(k+2), -(k+6)), Down_k -> (-(k+2), k/3)
  function automatic void ref_swing(input int s, output int vx, output int vy,
                                    output bit kind, output bit can);
    int k;
    vx = 0; vy = 0; kind = 1'b0; can = 1'b0;
    if (s >= 2 && s <= 8) begin
      k = s - 1; vx = -(k + 2); vy = -(k + 6); kind = 1'b0; can = 1'b1;
    end else if (s >= 9 && s <= 20) begin
      k = s - 8; vx = -(k + 2); vy = k / 3; kind = 1'b1; can = 1'b1;
    end
  endfunction

  function automatic bit ref_hit();
    int vx, vy;
    bit kind, can, ov;
    ref_swing(c_s, vx, vy, kind, can);
    ov = c_aw > 0 && c_ah > 0 && c_bw > 0 && c_bh > 0 &&
         c_ax < c_bx + c_bw && c_bx < c_ax + c_aw &&
         c_ay < c_by + c_bh && c_by < c_ay + c_ah;
    return c_fl && !(c_ax == 0 && c_ay == 0) && can && ov;
  endfunction

  task automatic apply_stim();
    pat_B_collision       = '{12'(c_aw), 12'(c_ah), 12'(c_ax), 12'(c_ay)};
    shuttle_box           = '{12'(c_bw), 12'(c_bh), 12'(c_bx), 12'(c_by)};
    pat_B_curr_state_name = pat_B_state_name'(c_s);
    shuttle_in_flight     = c_fl;
  endtask

  task automatic set_case(input int ax, input int ay, input int aw, input int ah,
                          input int bx, input int by, input int bw, input int bh,
                          input int s, input bit fl);
    c_ax = ax; c_ay = ay; c_aw = aw; c_ah = ah;
    c_bx = bx; c_by = by; c_bw = bw; c_bh = bh;
    c_s = s; c_fl = fl;
    apply_stim();
  endtask

  task automatic random_stim();
    int base;
    base = ($urandom_range(0, 7) == 0) ? 4050 : 0;
    c_ax = base + $urandom_range(0, 40); c_ay = base + $urandom_range(0, 40);
    c_aw = $urandom_range(0, 24);        c_ah = $urandom_range(0, 24);
    if ($urandom_range(0, 7) == 0) begin c_ax = 0; c_ay = 0; end
    c_bx = base + $urandom_range(0, 40); c_by = base + $urandom_range(0, 40);
    c_bw = $urandom_range(0, 12);        c_bh = $urandom_range(0, 12);
    c_s  = $urandom_range(0, 20);
    c_fl = ($urandom_range(0, 7) != 0);
    apply_stim();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame tick followed by the evaluation cycle: a hit is visible on return
  task automatic frame();
    write_finished = 1'b1;
    step();
    write_finished = 1'b0;
    step();
  endtask

  task automatic ack();
    hit_ready = 1'b1;
    step();
    hit_ready = 1'b0;
  endtask

  task automatic drain();
    repeat (4) frame();
  endtask

  task automatic bump_count();
    if (exp_count < 255) exp_count++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; write_finished = 1'b0; hit_ready = 1'b0;
    set_case(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    repeat (2) step();
    vectors++;
    if (hit_valid !== 1'b0 || hit_vx !== 12'sd0 || hit_vy !== 12'sd0 || hit_kind !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b vx=%0d vy=%0d kind=%b, want all 0",
               hit_valid, hit_vx, hit_vy, hit_kind);
    end
    vectors++;
    if (hit_count !== 8'd0 || z_count !== 8'd0 || z_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_count: got count=%0d z_count=%0d z_valid=%b, want 0", hit_count, z_count, z_valid);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_hit();
    set_case(100, 100, 20, 20, 110, 110, 8, 8, 14, 1'b1);
    write_finished = 1'b1;
    step();
    write_finished = 1'b0;
    vectors++;
    if (hit_valid !== 1'b0) begin
      miscompares++; $display("FAIL basic_latency_t1: got valid=%b want 0", hit_valid);
    end
    step();
    vectors++;
    if (hit_valid !== 1'b1 || int'(hit_vx) !== -8 || int'(hit_vy) !== 2 || hit_kind !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_hit: got valid=%b vx=%0d vy=%0d kind=%b want 1 -8 2 1", hit_valid, hit_vx, hit_vy, hit_kind);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (hit_valid !== 1'b1 || int'(hit_vx) !== -8 || int'(hit_vy) !== 2 || hit_kind !== 1'b1) begin
        miscompares++;
        $display("FAIL basic_hold%0d: got valid=%b vx=%0d vy=%0d kind=%b want 1 -8 2 1",
                 i, hit_valid, hit_vx, hit_vy, hit_kind);
      end
    end
    ack();
    bump_count();
    vectors++;
    if (hit_valid !== 1'b0 || hit_count !== 8'(exp_count)) begin
      miscompares++;
      $display("FAIL basic_ack: got valid=%b count=%0d want 0 %0d", hit_valid, hit_count, exp_count);
    end
    vectors++;
    if (int'(hit_vx) !== -8 || int'(hit_vy) !== 2 || hit_kind !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_payload_kept: got vx=%0d vy=%0d kind=%b want -8 2 1", hit_vx, hit_vy, hit_kind);
    end
    drain();
  endtask

  task automatic test_boundary();
    // ax ay aw ah bx by bw bh state in_flight expected_hit
    int bt [13][11];
    int evx, evy;
    bit ek, can;
    bt = '{
      '{100, 100, 20, 20, 120, 110, 8, 8, 14, 1, 0},
      '{100, 100, 20, 20, 119, 110, 8, 8, 14, 1, 1},
      '{0,   0,   20, 20, 0,   0,   8, 8, 14, 1, 0},
      '{100, 100, 20, 20, 110, 110, 8, 8, 0,  1, 0},
      '{100, 100, 20, 20, 110, 110, 8, 8, 14, 0, 0},
      '{100, 100, 20, 20, 110, 120, 8, 8, 14, 1, 0},
      '{100, 100, 20, 20, 110, 93,  8, 8, 14, 1, 1},
      '{100, 100, 20, 20, 110, 92,  8, 8, 14, 1, 0},
      '{100, 100, 20, 20, 92,  110, 8, 8, 14, 1, 0},
      '{100, 100, 20, 20, 110, 110, 0, 0, 14, 1, 0},
      '{4090, 4090, 20, 20, 4095, 4095, 8, 8, 14, 1, 1},
      '{100, 100, 0,  0,  96,  96,  8, 8, 14, 1, 0},
      '{0,   50,  20, 20, 5,   55,  8, 8, 5,  1, 1}
    };
    for (int i = 0; i < 13; i++) begin
      set_case(bt[i][0], bt[i][1], bt[i][2], bt[i][3], bt[i][4], bt[i][5],
               bt[i][6], bt[i][7], bt[i][8], 1'(bt[i][9]));
      frame();
      vectors++;
      if (hit_valid !== 1'(bt[i][10])) begin
        miscompares++;
        $display("FAIL boundary%0d: got valid=%b want %0d", i, hit_valid, bt[i][10]);
      end
      if (hit_valid === 1'b1) begin
        if (bt[i][10] == 1) begin
          ref_swing(bt[i][8], evx, evy, ek, can);
          vectors++;
          if (int'(hit_vx) !== evx || int'(hit_vy) !== evy || hit_kind !== ek) begin
            miscompares++;
            $display("FAIL boundary%0d_payload: got %0d %0d %b want %0d %0d %b",
                     i, hit_vx, hit_vy, hit_kind, evx, evy, ek);
          end
        end
        ack();
        bump_count();
        drain();
      end
    end
  endtask

  task automatic test_cooldown();
    set_case(100, 100, 20, 20, 110, 110, 8, 8, 3, 1'b1);
    frame();
    vectors++;
    if (hit_valid !== 1'b1) begin
      miscompares++; $display("FAIL cooldown_first: got valid=%b want 1", hit_valid);
    end
    ack();
    bump_count();
    for (int t = 1; t <= 4; t++) begin
      frame();
      vectors++;
      if (hit_valid !== 1'b0) begin
        miscompares++; $display("FAIL cooldown_tick%0d: got valid=%b want 0", t, hit_valid);
      end
    end
    frame();
    vectors++;
    if (hit_valid !== 1'b1 || int'(hit_vx) !== -4 || int'(hit_vy) !== -8 || hit_kind !== 1'b0) begin
      miscompares++;
      $display("FAIL cooldown_rehit: got valid=%b vx=%0d vy=%0d kind=%b want 1 -4 -8 0",
               hit_valid, hit_vx, hit_vy, hit_kind);
    end
    ack();
    bump_count();
    vectors++;
    if (hit_count !== 8'(exp_count)) begin
      miscompares++; $display("FAIL cooldown_count: got %0d want %0d", hit_count, exp_count);
    end
    drain();
  endtask

  task automatic test_tick_during_report();
    set_case(100, 100, 20, 20, 110, 110, 8, 8, 3, 1'b1);
    frame();
    vectors++;
    if (hit_valid !== 1'b1) begin
      miscompares++; $display("FAIL tdr_hit: got valid=%b want 1", hit_valid);
    end
    write_finished = 1'b1;
    ack();
    write_finished = 1'b0;
    bump_count();
    vectors++;
    if (hit_valid !== 1'b0 || hit_count !== 8'(exp_count)) begin
      miscompares++;
      $display("FAIL tdr_ack: got valid=%b count=%0d want 0 %0d", hit_valid, hit_count, exp_count);
    end
    for (int t = 1; t <= 4; t++) begin
      frame();
      vectors++;
      if (hit_valid !== 1'b0) begin
        miscompares++; $display("FAIL tdr_tick%0d: got valid=%b want 0", t, hit_valid);
      end
    end
    frame();
    vectors++;
    if (hit_valid !== 1'b1) begin
      miscompares++; $display("FAIL tdr_rehit: got valid=%b want 1", hit_valid);
    end
    ack();
    bump_count();
    drain();
  endtask

  task automatic test_random();
    int evx, evy;
    bit ek, can, eh;
    for (int n = 0; n < 150; n++) begin
      random_stim();
      ref_swing(c_s, evx, evy, ek, can);
      eh = ref_hit();
      hit_ready = 1'($urandom_range(0, 1));
      frame();
      hit_ready = 1'b0;
      vectors++;
      if (hit_valid !== eh) begin
        miscompares++;
        $display("FAIL rand%0d_valid: got %b want %b (state %0d fl %b)", n, hit_valid, eh, c_s, c_fl);
      end
      if (hit_valid === 1'b1) begin
        if (eh) begin
          vectors++;
          if (int'(hit_vx) !== evx || int'(hit_vy) !== evy || hit_kind !== ek) begin
            miscompares++;
            $display("FAIL rand%0d_payload: got %0d %0d %b want %0d %0d %b",
                     n, hit_vx, hit_vy, hit_kind, evx, evy, ek);
          end
        end
        repeat ($urandom_range(0, 3)) begin
          write_finished = 1'($urandom_range(0, 1));
          step();
          write_finished = 1'b0;
          vectors++;
          if (hit_valid !== 1'b1) begin
            miscompares++; $display("FAIL rand%0d_hold: got valid=%b want 1", n, hit_valid);
          end
        end
        write_finished = 1'($urandom_range(0, 1));
        ack();
        write_finished = 1'b0;
        bump_count();
        vectors++;
        if (hit_count !== 8'(exp_count)) begin
          miscompares++; $display("FAIL rand%0d_count: got %0d want %0d", n, hit_count, exp_count);
        end
        for (int t = 0; t < 4; t++) begin
          random_stim();
          hit_ready = 1'($urandom_range(0, 1));
          frame();
          hit_ready = 1'b0;
          vectors++;
          if (hit_valid !== 1'b0) begin
            miscompares++; $display("FAIL rand%0d_lockout%0d: got valid=%b want 0", n, t, hit_valid);
          end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    set_case(100, 100, 20, 20, 110, 110, 8, 8, 14, 1'b1);
    frame();
    vectors++;
    if (hit_valid !== 1'b1) begin
      miscompares++; $display("FAIL arst_pre: got valid=%b want 1", hit_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_count = 0;
    vectors++;
    if (hit_valid !== 1'b0 || hit_count !== 8'd0) begin
      miscompares++;
      $display("FAIL arst_immediate: got valid=%b count=%0d want 0 0", hit_valid, hit_count);
    end
    vectors++;
    if (hit_vx !== 12'sd0 || hit_vy !== 12'sd0 || hit_kind !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_payload: got vx=%0d vy=%0d kind=%b want 0 0 0", hit_vx, hit_vy, hit_kind);
    end
    step();
    step();
    rst_n = 1'b1;
    frame();
    vectors++;
    if (hit_valid !== 1'b1 || int'(hit_vx) !== -8 || int'(hit_vy) !== 2 || hit_kind !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_after: got valid=%b vx=%0d vy=%0d kind=%b want 1 -8 2 1",
               hit_valid, hit_vx, hit_vy, hit_kind);
    end
    ack();
    bump_count();
    vectors++;
    if (hit_count !== 8'(exp_count)) begin
      miscompares++; $display("FAIL arst_count: got %0d want %0d", hit_count, exp_count);
    end
    drain();
  endtask

  task automatic test_saturation();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    set_case(100, 100, 20, 20, 110, 110, 8, 8, 3, 1'b1);
    for (int i = 0; i < 255; i++) begin
      frame();
      vectors++;
      if (z_valid !== 1'b1) begin
        miscompares++; $display("FAIL sat_hit%0d: got valid=%b want 1", i, z_valid);
      end
      ack();
    end
    vectors++;
    if (z_count !== 8'd255) begin
      miscompares++; $display("FAIL sat_255: got %0d want 255", z_count);
    end
    frame();
    vectors++;
    if (z_valid !== 1'b1) begin
      miscompares++; $display("FAIL sat_extra_hit: got valid=%b want 1", z_valid);
    end
    ack();
    vectors++;
    if (z_count !== 8'd255 || z_valid !== 1'b0) begin
      miscompares++; $display("FAIL sat_hold: got count=%0d valid=%b want 255 0", z_count, z_valid);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_hit();
    test_boundary();
    test_cooldown();
    test_tick_during_report();
    test_random();
    test_async_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
